// File: rtl/lfsr_pkg.sv
// Shared constants for the 5-bit Fibonacci LFSR keystream generator.
package lfsr_pkg;

  localparam int STATE_W = 5;
  localparam int OUT_W   = 22;
  localparam int CNT_W   = 5;

  // Any non-zero value works; all-zero would lock the register up.
  localparam logic [STATE_W-1:0] DEFAULT_SEED = 5'b00001;

  // x^5 + x^3 + 1: output tap and second feedback tap.
  localparam int TAP_A = 0;
  localparam int TAP_B = 2;

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with feedback logic; advances only when en is high.
module lfsr_core #(
  parameter int                   STATE_W = lfsr_pkg::STATE_W,
  parameter logic [STATE_W-1:0]   SEED    = lfsr_pkg::DEFAULT_SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic out_bit
);
  import lfsr_pkg::*;

  logic [STATE_W-1:0] state_q, state_d;
  logic               fb;

  // Next state: shift right and insert feedback at the MSB.
  always_comb begin
    fb      = state_q[TAP_A] ^ state_q[TAP_B];
    state_d = state_q;
    if (en) state_d = {fb, state_q[STATE_W-1:1]};
  end

  // State register, seeded while reset is held low.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign out_bit = state_q[TAP_A];

endmodule

// File: rtl/lfsr_keystream.sv
// Keystream generator: runs the LFSR for a latched number of rounds,
// collects output bits into a shift register, then halts with done set.
module lfsr_keystream #(
  parameter int                 STATE_W = lfsr_pkg::STATE_W,
  parameter logic [STATE_W-1:0] SEED    = lfsr_pkg::DEFAULT_SEED,
  parameter int                 OUT_W   = lfsr_pkg::OUT_W,
  parameter int                 CNT_W   = lfsr_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] rounds,
  output logic [OUT_W-1:0] bitstream,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rounds_q;
  logic [OUT_W-1:0] bitstream_q, bitstream_d;
  logic             done_q, done_d;
  logic             step;
  logic             out_bit;

  assign step = (count_q < rounds_q);

  lfsr_core #(
    .STATE_W (STATE_W),
    .SEED    (SEED)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .en      (step),
    .out_bit (out_bit)
  );

  // Step bookkeeping: shift in the output bit, count, flag the last step.
  always_comb begin
    count_d     = count_q;
    bitstream_d = bitstream_q;
    done_d      = done_q;
    if (step) begin
      count_d     = count_q + 1'b1;
      bitstream_d = {bitstream_q[OUT_W-2:0], out_bit};
      done_d      = (count_d == rounds_q);
    end
  end

  // Registers; reset reinitialises everything and latches the round count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q     <= '0;
      rounds_q    <= rounds;
      bitstream_q <= '0;
      done_q      <= (rounds == '0);
    end else begin
      count_q     <= count_d;
      bitstream_q <= bitstream_d;
      done_q      <= done_d;
    end
  end

  assign bitstream = bitstream_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lfsr_keystream.sv
// Randomised bench for lfsr_keystream against a bit-sequence reference.
module tb_lfsr_keystream;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rounds;
  logic [21:0] bitstream;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // Reference: the output bit sequence a[k] obeys a[k+5] = a[k] ^ a[k+2],
  // with a[0..4] equal to the seed bits LSB first.
  bit seq [0:63];
  int m_rounds = 0;
  int m_n      = 0;

  lfsr_keystream dut (
    .clk       (clk),
    .reset     (reset),
    .rounds    (rounds),
    .bitstream (bitstream),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] exp_bs(input int n);
    logic [21:0] r = '0;
    for (int k = 0; k < n; k++) r = {r[20:0], seq[k]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given inputs; model advances, outputs checked.
  task automatic step(input logic rst, input logic [4:0] rnd);
    reset  = rst;
    rounds = rnd;
    @(posedge clk);
    if (!rst) begin
      m_rounds = int'(rnd);
      m_n      = 0;
    end else if (m_n < m_rounds) begin
      m_n++;
    end
    #1;
    chk("bitstream", 32'(bitstream), 32'(exp_bs(m_n)));
    chk("done", 32'(done), 32'(m_n == m_rounds));
  endtask

  initial begin
    logic [4:0] seed = 5'b00001;
    for (int i = 0; i < 5; i++) seq[i] = seed[i];
    for (int k = 0; k + 5 < 64; k++) seq[k+5] = seq[k] ^ seq[k+2];

    reset  = 1'b0;
    rounds = 5'd10;
    @(negedge clk);

    // Reset state
    step(1'b0, 5'd10);
    step(1'b0, 5'd10);
    chk("rst_state", 32'(dut.u_core.state_q), 32'h01);

    // Directed rounds=10 run with known values
    for (int e = 1; e <= 14; e++) begin
      step(1'b1, 5'd10);
      if (e == 1)  chk("plan_e1",  32'(bitstream), 32'h000001);
      if (e == 6)  chk("plan_e6",  32'(bitstream), 32'h000021);
      if (e == 9)  chk("plan_e9_done", 32'(done), 32'h0);
      if (e == 10) chk("plan_e10", 32'(bitstream), 32'h000212);
      if (e >= 10) chk("plan_hold", 32'(bitstream), 32'h000212);
    end

    // rounds=0: never steps, done from reset
    step(1'b0, 5'd0);
    chk("zero_done_rst", 32'(done), 32'h1);
    for (int e = 0; e < 20; e++) step(1'b1, 5'd0);
    chk("zero_bs", 32'(bitstream), 32'h0);

    // rounds changed after release is ignored
    step(1'b0, 5'd20);
    for (int e = 1; e <= 24; e++) step(1'b1, (e > 2) ? 5'd3 : 5'd20);
    chk("ignore_rounds", 32'(bitstream), 32'(exp_bs(20)));

    // Full period: 31 steps, last 22 bits retained
    step(1'b0, 5'd31);
    for (int e = 1; e <= 33; e++) step(1'b1, 5'd31);
    chk("period_state", 32'(dut.u_core.state_q), 32'h01);

    // Mid-run abort
    step(1'b0, 5'd10);
    for (int e = 1; e <= 5; e++) step(1'b1, 5'd10);
    step(1'b0, 5'd10);
    chk("abort_bs", 32'(bitstream), 32'h0);
    for (int e = 1; e <= 10; e++) step(1'b1, 5'd10);
    chk("abort_rerun", 32'(bitstream), 32'h000212);

    // Randomised runs with random rounds, input noise and occasional aborts
    for (int run = 0; run < 40; run++) begin
      logic [4:0] r = 5'($urandom_range(0, 31));
      int extra = $urandom_range(0, 6);
      int nrst  = $urandom_range(1, 2);
      for (int i = 0; i < nrst; i++) step(1'b0, r);
      for (int e = 0; e < int'(r) + extra; e++) begin
        if ($urandom_range(0, 60) == 0) step(1'b0, 5'($urandom));
        else step(1'b1, 5'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
